// File: rtl/io_bus_master.sv
// io_bus_master: turns single valid/ready requests into one-cycle accesses on the
// shared device bus and returns the result on a valid/ready response channel.
//
// state  | meaning
// IDLE   | bus idle, req_ready high, waiting for a request
// ACCESS | exactly one selected device enabled for one cycle
// RESP   | bus idle, response held until the consumer takes it
module io_bus_master #(
  parameter int NUM_DEVICES = 4,
  parameter int DEV_W       = 3,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [DEV_W-1:0]       req_device,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic [NUM_DEVICES-1:0] bus_enable,
  output logic                   bus_mode,
  output logic [ADDR_W-1:0]      bus_address,
  output logic [DATA_W-1:0]      bus_wdata,
  input  logic [DATA_W-1:0]      bus_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [DEV_W:0] NUM_DEV_L = (DEV_W + 1)'(NUM_DEVICES);

  state_e                 state_q, state_d;
  logic [NUM_DEVICES-1:0] bus_enable_q, bus_enable_d;
  logic                   bus_mode_q, bus_mode_d;
  logic [ADDR_W-1:0]      bus_address_q, bus_address_d;
  logic [DATA_W-1:0]      bus_wdata_q, bus_wdata_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_err_q, rsp_err_d;

  logic                   dev_ok;
  logic [NUM_DEVICES-1:0] dev_sel;

  // Widen by one bit so the range check never truncates NUM_DEVICES.
  assign dev_ok = ({1'b0, req_device} < NUM_DEV_L);

  always_comb begin
    dev_sel = '0;
    for (int i = 0; i < NUM_DEVICES; i++) begin
      if (req_device == DEV_W'(i)) dev_sel[i] = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    bus_enable_d  = '0;
    bus_mode_d    = 1'b0;
    bus_address_d = '0;
    bus_wdata_d   = '0;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (dev_ok) begin
            bus_enable_d  = dev_sel;
            bus_mode_d    = ~req_write;
            bus_address_d = req_addr;
            bus_wdata_d   = req_write ? req_wdata : '0;
            state_d       = ACCESS;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            state_d     = RESP;
          end
        end
      end
      ACCESS: begin
        // bus_mode_q still holds the read flag of the access in flight.
        rsp_rdata_d = bus_mode_q ? bus_rdata : '0;
        rsp_err_d   = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      bus_enable_q  <= '0;
      bus_mode_q    <= 1'b0;
      bus_address_q <= '0;
      bus_wdata_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      bus_enable_q  <= bus_enable_d;
      bus_mode_q    <= bus_mode_d;
      bus_address_q <= bus_address_d;
      bus_wdata_q   <= bus_wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign bus_enable  = bus_enable_q;
  assign bus_mode    = bus_mode_q;
  assign bus_address = bus_address_q;
  assign bus_wdata   = bus_wdata_q;

endmodule

// File: tb/tb_io_bus_master.sv
// Bench for io_bus_master: device model on the bus side, transaction-level
// reference model checked every cycle, directed table plus random traffic.
module tb_io_bus_master;
  localparam int ND = 4;
  localparam int DVW = 3;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [DVW-1:0] req_device = '0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [ND-1:0] bus_enable;
  logic          bus_mode;
  logic [AW-1:0] bus_address;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;

  logic man_ready = 1'b1;
  logic rnd_bit = 1'b1;
  logic rnd_on = 1'b0;
  assign rsp_ready = rnd_on ? rnd_bit : man_ready;

  always #5 clk = ~clk;

  io_bus_master #(.NUM_DEVICES(ND), .DEV_W(DVW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_device(req_device), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_enable(bus_enable), .bus_mode(bus_mode), .bus_address(bus_address),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Responders: act on the falling edge, drive read data for the second half.
  logic [DW-1:0] dev_mem [ND][16];
  logic [DW-1:0] ref_mem [ND][16];
  logic [DW-1:0] rdata_drv = 8'hA5;
  assign bus_rdata = rdata_drv;

  always @(negedge clk) begin
    rdata_drv = 8'hA5;
    for (int i = 0; i < ND; i++) begin
      if (bus_enable[i]) begin
        if (bus_mode) rdata_drv = dev_mem[i][bus_address];
        else dev_mem[i][bus_address] = bus_wdata;
      end
    end
  end

  // Transaction-level reference and protocol monitor.
  typedef struct { logic [DW-1:0] rdata; logic err; } rsp_t;
  rsp_t rsp_q[$];
  int   en_cycles[$];
  logic mon_en = 1'b0;
  logic busy = 1'b0, vis = 1'b0, bus_pend = 1'b0;
  int   due = 0;
  int   cyc = 0;
  logic [ND-1:0] prev_en = '0, exp_en;
  logic exp_mode;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wd;

  always @(negedge clk) begin
    if (mon_en) begin
      rsp_t r;
      cyc++;
      chk("req_ready", req_ready, !busy);
      chk("en_onehot", ($countones(bus_enable) <= 1), 1);
      chk("en_back_to_back", (bus_enable != 0 && prev_en != 0), 0);
      if (bus_enable != 0) en_cycles.push_back(cyc);
      if (bus_pend) begin
        chk("bus_enable", bus_enable, exp_en);
        chk("bus_mode", bus_mode, exp_mode);
        chk("bus_address", bus_address, exp_addr);
        chk("bus_wdata", bus_wdata, exp_wd);
        bus_pend = 1'b0;
      end else begin
        chk("bus_idle", {bus_enable, bus_mode, bus_address, bus_wdata}, 0);
      end
      if (due > 0) begin
        due--;
        if (due == 0) vis = 1'b1;
      end
      chk("rsp_valid", rsp_valid, vis);
      if (vis && rsp_q.size() > 0) begin
        chk("rsp_rdata", rsp_rdata, rsp_q[0].rdata);
        chk("rsp_err", rsp_err, rsp_q[0].err);
      end
      if (vis && rsp_ready) begin
        if (rsp_q.size() > 0) void'(rsp_q.pop_front());
        vis = 1'b0;
        busy = 1'b0;
      end else if (req_valid && req_ready && !reset) begin
        busy = 1'b1;
        if (req_device < ND) begin
          bus_pend = 1'b1;
          exp_en = ND'(1) << req_device;
          exp_mode = !req_write;
          exp_addr = req_addr;
          exp_wd = req_write ? req_wdata : '0;
          due = 2;
          if (req_write) begin
            ref_mem[req_device[1:0]][req_addr] = req_wdata;
            r.rdata = '0;
          end else begin
            r.rdata = ref_mem[req_device[1:0]][req_addr];
          end
          r.err = 1'b0;
        end else begin
          due = 1;
          r.rdata = '0;
          r.err = 1'b1;
        end
        rsp_q.push_back(r);
      end
      if (reset) begin
        busy = 1'b0; vis = 1'b0; bus_pend = 1'b0; due = 0;
        rsp_q.delete();
      end
      prev_en = bus_enable;
    end
  end

  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom_range(0, 2) != 0);
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic issue(input logic w, input logic [DVW-1:0] d, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd);
    int n = 0;
    req_valid = 1'b1; req_write = w; req_device = d; req_addr = a; req_wdata = wd;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 200);
    chk("accept_timeout", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  typedef struct {
    logic           w;
    logic [DVW-1:0] dev;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    logic [DW-1:0]  exp_rdata;
    logic           exp_err;
  } vec_t;

  initial begin : main
    vec_t vecs[10];
    int lat;
    for (int i = 0; i < ND; i++)
      for (int j = 0; j < 16; j++) begin
        dev_mem[i][j] = '0;
        ref_mem[i][j] = '0;
      end

    vecs[0] = '{1'b1, 3'd0, 4'd3,  8'h80, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 3'd0, 4'd3,  8'h00, 8'h80, 1'b0};
    vecs[2] = '{1'b0, 3'd5, 4'd1,  8'h00, 8'h00, 1'b1};
    vecs[3] = '{1'b1, 3'd3, 4'd15, 8'h5A, 8'h00, 1'b0};
    vecs[4] = '{1'b0, 3'd3, 4'd15, 8'h00, 8'h5A, 1'b0};
    vecs[5] = '{1'b1, 3'd7, 4'd2,  8'h77, 8'h00, 1'b1};
    vecs[6] = '{1'b0, 3'd1, 4'd0,  8'h00, 8'h00, 1'b0};
    vecs[7] = '{1'b1, 3'd2, 4'd1,  8'hFF, 8'h00, 1'b0};
    vecs[8] = '{1'b0, 3'd2, 4'd1,  8'h00, 8'hFF, 1'b0};
    vecs[9] = '{1'b0, 3'd0, 4'd3,  8'h00, 8'h80, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {bus_enable, bus_mode, bus_address, bus_wdata, rsp_valid, rsp_rdata, rsp_err}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", req_ready, 1);
    @(posedge clk); #1;

    // Directed table, response consumed immediately.
    for (int k = 0; k < 10; k++) begin
      issue(vecs[k].w, vecs[k].dev, vecs[k].addr, vecs[k].wdata);
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!rsp_valid && lat < 20);
      chk($sformatf("vec%0d_latency", k), lat, vecs[k].exp_err ? 1 : 2);
      chk($sformatf("vec%0d_rdata", k), rsp_rdata, vecs[k].exp_rdata);
      chk($sformatf("vec%0d_err", k), rsp_err, vecs[k].exp_err);
      @(posedge clk); #1;
      if (k == 0) chk("dev0_reg3", dev_mem[0][3], 8'h80);
    end

    // Back-pressure: response must hold while the consumer stalls.
    man_ready = 1'b0;
    issue(1'b0, 3'd3, 4'd15, 8'h00);
    repeat (6) @(negedge clk);
    chk("bp_rsp_valid", rsp_valid, 1);
    chk("bp_rsp_rdata", rsp_rdata, 8'h5A);
    chk("bp_req_ready", req_ready, 0);
    chk("bp_bus_idle", bus_enable, 0);
    @(posedge clk); #1;
    man_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_release_ready", req_ready, 1);
    chk("bp_release_valid", rsp_valid, 0);
    @(posedge clk); #1;

    // Back-to-back with req_valid held high.
    en_cycles.delete();
    req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      req_write = (k % 2 == 0); req_device = 3'd1; req_addr = 4'd2;
      req_wdata = 8'h30 + 8'(k);
      do begin
        @(negedge clk);
        n++;
      end while (!req_ready && n < 20);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("b2b_count", en_cycles.size(), 4);
    for (int k = 1; k < en_cycles.size(); k++)
      chk($sformatf("b2b_spacing%0d", k), en_cycles[k] - en_cycles[k-1], 3);

    // Reset while a read is on the bus.
    issue(1'b0, 3'd2, 4'd1, 8'h00);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_enable", bus_enable, 0);
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    chk("rst_mid_req_ready", req_ready, 1);
    @(posedge clk); #1;

    // Random traffic, random consumer stalls, reference model checks all.
    rnd_on = 1'b1;
    for (int k = 0; k < 250; k++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
      issue(1'($urandom_range(0, 1)), DVW'($urandom_range(0, 5)), AW'($urandom),
            DW'($urandom));
    end
    rnd_on = 1'b0;
    man_ready = 1'b1;
    for (int n = 0; n < 100 && (busy || rsp_q.size() != 0); n++) @(posedge clk);
    chk("drain_busy", busy, 0);
    chk("drain_queue", rsp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
